// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine front-end:
// buffer capacities, matcher metacharacters and the feeder state encoding.
package sme_pkg;

   localparam int STR_MAX = 32;
   localparam int PAT_MAX = 8;

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_SPACE  = 8'h20;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_SEND_S,
      ST_SEND_P,
      ST_WAIT
   } feed_state_t;

endpackage

// File: rtl/sme_rec_buf.sv
// Record buffer: one synchronous write port, one combinational read port; no backpressure.
// Contents are not reset; stale bytes are never read because lengths are reset.
module sme_rec_buf #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  logic [7:0]               wr_dat,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [7:0]               rd_dat
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_idx] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/sme_feeder.sv
// Buffers string/pattern records and replays them as back-to-back matcher bursts starting the
// cycle after the pattern's last byte; in_ready is low (no bytes taken) from burst start until WAIT ends.
module sme_feeder #(
   parameter int STR_MAX  = sme_pkg::STR_MAX,
   parameter int PAT_MAX  = sme_pkg::PAT_MAX,
   parameter int WAIT_MAX = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_kind,
   input  logic       in_last,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       sme_valid,
   output logic       run_active,
   output logic       ovf,
   output logic       timeout
);
   import sme_pkg::*;

   localparam int SAW = $clog2(STR_MAX);
   localparam int PAW = $clog2(PAT_MAX);
   localparam int WW  = $clog2(WAIT_MAX + 1);

   feed_state_t   state;
   logic          s_pend;
   logic          in_rec;
   logic          rec_kind;
   logic          rec_drop;
   logic [5:0]    slen;
   logic [5:0]    plen;
   logic [5:0]    idx;
   logic [WW-1:0] wcnt;

   logic          accept;
   logic          first;
   logic          kind;
   logic [5:0]    base_len;
   logic [5:0]    len_nxt;
   logic          full;
   logic          s_we;
   logic          p_we;
   logic [SAW-1:0] s_ra;
   logic [PAW-1:0] p_ra;
   logic [7:0]    s_rd;
   logic [7:0]    p_rd;
   logic [7:0]    p_head;

   // in_ready is only ever high in FILL, so it alone qualifies a handshake.
   assign accept   = in_valid && in_ready;
   assign first    = !in_rec;
   assign kind     = first ? in_kind : rec_kind;
   assign base_len = first ? 6'd0 : (kind ? plen : slen);
   assign full     = kind ? (base_len >= 6'(PAT_MAX)) : (base_len >= 6'(STR_MAX));
   assign len_nxt  = base_len + {5'd0, !full};
   assign s_we     = accept && !kind && !full;
   assign p_we     = accept && kind && !full;
   assign s_ra     = (state == ST_SEND_S) ? idx[SAW-1:0] : '0;
   assign p_ra     = (state == ST_SEND_P) ? idx[PAW-1:0] : '0;
   // A one-byte pattern is still being written when its burst starts.
   assign p_head   = first ? in_data : p_rd;

   sme_rec_buf #(.DEPTH(STR_MAX)) u_sbuf (
      .clk    (clk),
      .we     (s_we),
      .wr_idx (base_len[SAW-1:0]),
      .wr_dat (in_data),
      .rd_idx (s_ra),
      .rd_dat (s_rd)
   );

   sme_rec_buf #(.DEPTH(PAT_MAX)) u_pbuf (
      .clk    (clk),
      .we     (p_we),
      .wr_idx (base_len[PAW-1:0]),
      .wr_dat (in_data),
      .rd_idx (p_ra),
      .rd_dat (p_rd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_FILL;
         s_pend     <= 1'b0;
         in_rec     <= 1'b0;
         rec_kind   <= 1'b0;
         rec_drop   <= 1'b0;
         slen       <= 6'd0;
         plen       <= 6'd0;
         idx        <= 6'd0;
         wcnt       <= '0;
         in_ready   <= 1'b0;
         chardata   <= 8'd0;
         isstring   <= 1'b0;
         ispattern  <= 1'b0;
         run_active <= 1'b0;
         ovf        <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         ovf     <= 1'b0;
         timeout <= 1'b0;
         case (state)
            ST_FILL: begin
               in_ready <= 1'b1;
               if (accept) begin
                  in_rec   <= !in_last;
                  rec_kind <= kind;
                  rec_drop <= (!first && rec_drop) || full;
                  if (kind) begin
                     plen <= len_nxt;
                  end else begin
                     slen   <= len_nxt;
                     s_pend <= in_last;
                  end
                  if (in_last) begin
                     ovf <= (!first && rec_drop) || full;
                     if (kind) begin
                        in_ready <= 1'b0;
                        idx      <= 6'd1;
                        if (s_pend) begin
                           state    <= ST_SEND_S;
                           isstring <= 1'b1;
                           chardata <= s_rd;
                        end else begin
                           state     <= ST_SEND_P;
                           ispattern <= 1'b1;
                           chardata  <= p_head;
                        end
                     end
                  end
               end
            end
            ST_SEND_S: begin
               if (idx < slen) begin
                  chardata <= s_rd;
                  idx      <= idx + 6'd1;
               end else begin
                  state     <= ST_SEND_P;
                  isstring  <= 1'b0;
                  ispattern <= 1'b1;
                  chardata  <= p_rd;
                  idx       <= 6'd1;
                  s_pend    <= 1'b0;
               end
            end
            ST_SEND_P: begin
               if (idx < plen) begin
                  chardata <= p_rd;
                  idx      <= idx + 6'd1;
               end else begin
                  state      <= ST_WAIT;
                  ispattern  <= 1'b0;
                  chardata   <= 8'd0;
                  run_active <= 1'b1;
                  wcnt       <= WW'(1);
               end
            end
            ST_WAIT: begin
               if (sme_valid) begin
                  state      <= ST_FILL;
                  run_active <= 1'b0;
                  in_ready   <= 1'b1;
               end else if (wcnt == WW'(WAIT_MAX)) begin
                  state      <= ST_FILL;
                  run_active <= 1'b0;
                  in_ready   <= 1'b1;
                  timeout    <= 1'b1;
               end else begin
                  wcnt <= wcnt + WW'(1);
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: table of record sequences with expected bursts,
// plus hand-written timeout and mid-burst reset sequences.
module tb_sme_feeder;
   import sme_pkg::*;

   localparam int WAIT_MAX = 16;

   typedef logic [7:0] bq_t[$];

   typedef struct {
      string s1;
      string s2;
      string p;
      bit    gap;
      string exp_s;
      string exp_p;
      int    exp_ovf;
      int    sv_delay;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_kind;
   logic       in_last;
   logic [7:0] chardata;
   logic       isstring;
   logic       ispattern;
   logic       sme_valid;
   logic       run_active;
   logic       ovf;
   logic       timeout;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;
   int last_drive;

   bq_t sq;
   bq_t pq;
   int  n_strobe, first_c, last_c, ra_first, ra_cnt, ovf_cnt, to_cnt, to_cyc;
   bit  saw_p, order_bad;

   vec_t vecs[6];
   vec_t post;

   sme_feeder #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_kind    (in_kind),
      .in_last    (in_last),
      .chardata   (chardata),
      .isstring   (isstring),
      .ispattern  (ispattern),
      .sme_valid  (sme_valid),
      .run_active (run_active),
      .ovf        (ovf),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, need %0d", name, act, exp);
   endtask

   function automatic int q_mismatch(input bq_t q, input string s);
      if (q.size() != s.len()) return q.size() + 1000;
      foreach (q[i]) if (q[i] != s[i]) return i;
      return -1;
   endfunction

   task automatic clear_log();
      sq.delete();
      pq.delete();
      n_strobe = 0; first_c = -1; last_c = -1; ra_first = -1; ra_cnt = 0;
      ovf_cnt = 0; to_cnt = 0; to_cyc = -1; saw_p = 0; order_bad = 0;
   endtask

   // Advance to the next falling edge and record what the DUT is driving.
   task automatic tick();
      @(negedge clk);
      if (isstring) begin
         sq.push_back(chardata);
         if (saw_p || ispattern) order_bad = 1;
      end
      if (ispattern) begin
         pq.push_back(chardata);
         saw_p = 1;
      end
      if (isstring || ispattern) begin
         if (n_strobe == 0) first_c = cyc;
         last_c = cyc;
         n_strobe++;
      end
      if (run_active) begin
         if (ra_first < 0) ra_first = cyc;
         ra_cnt++;
      end
      if (ovf) ovf_cnt++;
      if (timeout) begin
         to_cnt++;
         if (to_cyc < 0) to_cyc = cyc;
      end
   endtask

   task automatic send_rec(input bit kind, input string txt, input bit gap);
      int n;
      for (int i = 0; i < txt.len(); i++) begin
         if (gap && i > 0) begin
            in_valid = 1'b0;
            tick();
         end
         in_valid = 1'b1;
         in_data  = txt[i];
         in_kind  = kind;
         in_last  = (i == txt.len() - 1);
         n = 0;
         while (!in_ready && n < 200) begin
            tick();
            n++;
         end
         if (n >= 200) check(1'b0, "in_ready_wait", 0, 1);
         last_drive = cyc;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_kind  = 1'b0;
   endtask

   task automatic drive_case(input vec_t v);
      if (v.s1.len() > 0) send_rec(1'b0, v.s1, v.gap);
      if (v.s2.len() > 0) send_rec(1'b0, v.s2, v.gap);
      send_rec(1'b1, v.p, v.gap);
   endtask

   task automatic run_case(input vec_t v, input string tag);
      int n;
      clear_log();
      drive_case(v);
      n = 0;
      while (!run_active && n < 300) begin
         tick();
         n++;
      end
      check(run_active == 1'b1, {tag, "_run_active_seen"}, int'(run_active), 1);
      check(q_mismatch(sq, v.exp_s) == -1, {tag, "_string_burst(mismatch_at)"}, q_mismatch(sq, v.exp_s), -1);
      check(q_mismatch(pq, v.exp_p) == -1, {tag, "_pattern_burst(mismatch_at)"}, q_mismatch(pq, v.exp_p), -1);
      check(!order_bad && n_strobe == last_c - first_c + 1, {tag, "_burst_contiguous"},
            n_strobe, last_c - first_c + 1);
      check(first_c == last_drive + 1, {tag, "_burst_latency"}, first_c - last_drive, 1);
      check(ra_first == last_c + 1, {tag, "_run_active_rise"}, ra_first - last_c, 1);
      repeat (v.sv_delay) tick();
      sme_valid = 1'b1;
      tick();
      sme_valid = 1'b0;
      check(run_active == 1'b0 && in_ready == 1'b1, {tag, "_release_after_valid"},
            int'({run_active, in_ready}), 1);
      check(ovf_cnt == v.exp_ovf, {tag, "_ovf_pulses"}, ovf_cnt, v.exp_ovf);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{s1:"ab c", s2:"", p:"^c", gap:0, exp_s:"ab c", exp_p:"^c", exp_ovf:0, sv_delay:3};
      vecs[1] = '{s1:"", s2:"", p:"b*", gap:0, exp_s:"", exp_p:"b*", exp_ovf:0, sv_delay:1};
      vecs[2] = '{s1:"abcdefghijklmnopqrstuvwxyzABCDEFGHI", s2:"", p:"0123456789", gap:0,
                  exp_s:"abcdefghijklmnopqrstuvwxyzABCDEF", exp_p:"01234567", exp_ovf:2, sv_delay:2};
      vecs[3] = '{s1:"xyz", s2:"hello", p:"l.o", gap:0, exp_s:"hello", exp_p:"l.o", exp_ovf:0, sv_delay:1};
      vecs[4] = '{s1:"q.r$", s2:"", p:"r$", gap:1, exp_s:"q.r$", exp_p:"r$", exp_ovf:0, sv_delay:5};
      vecs[5] = '{s1:"z", s2:"", p:"z", gap:0, exp_s:"z", exp_p:"z", exp_ovf:0, sv_delay:1};
      post    = '{s1:"", s2:"", p:"x", gap:0, exp_s:"", exp_p:"x", exp_ovf:0, sv_delay:1};

      reset = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_kind = 1'b0; in_last = 1'b0; sme_valid = 1'b0;
      clear_log();
      tick();
      tick();
      check({in_ready, isstring, ispattern, run_active, ovf, timeout, chardata} == 14'd0,
            "reset_outputs", int'({in_ready, isstring, ispattern, run_active, ovf, timeout, chardata}), 0);
      reset = 1'b1;
      tick();
      check(in_ready == 1'b1, "ready_after_release", int'(in_ready), 1);

      for (int k = 0; k < 6; k++) run_case(vecs[k], $sformatf("v%0d", k));

      // WAIT with no matcher response
      clear_log();
      send_rec(1'b0, "ab", 1'b0);
      send_rec(1'b1, {"a", string'(CH_DOLLAR)}, 1'b0);
      for (int n = 0; n < 300 && to_cyc < 0; n++) tick();
      check(to_cyc >= 0, "timeout_seen", to_cyc, 0);
      check(ra_cnt == WAIT_MAX, "wait_length", ra_cnt, WAIT_MAX);
      check(to_cyc == ra_first + WAIT_MAX, "timeout_cycle", to_cyc - ra_first, WAIT_MAX);
      check(in_ready == 1'b1 && run_active == 1'b0, "fill_after_timeout",
            int'({in_ready, run_active}), 2);
      repeat (3) tick();
      check(to_cnt == 1, "timeout_single_pulse", to_cnt, 1);

      // Reset pulled during the string burst
      clear_log();
      send_rec(1'b0, "hello", 1'b0);
      send_rec(1'b1, "lo", 1'b0);
      check(isstring == 1'b1, "send_s_entered", int'(isstring), 1);
      reset = 1'b0;
      #1;
      check({in_ready, isstring, ispattern, run_active, ovf, timeout, chardata} == 14'd0,
            "mid_burst_reset_outputs",
            int'({in_ready, isstring, ispattern, run_active, ovf, timeout, chardata}), 0);
      tick();
      reset = 1'b1;
      tick();
      check(in_ready == 1'b1, "ready_after_mid_reset", int'(in_ready), 1);
      run_case(post, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
